// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg : pointer-encoding helpers and depth constant shared by the
//            async FIFO blocks (r2w sync, read controller, write scheduler).
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int ADDRSIZE_DEF = 4;
  localparam int DEPTH        = 2**ADDRSIZE_DEF;

  // Helpers work on any pointer width up to PTR_MAXW: callers zero-extend in
  // and truncate the result back to their own width.
  localparam int PTR_MAXW = 16;

  function automatic logic [PTR_MAXW-1:0] bin2gray(input logic [PTR_MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAXW-1:0] gray2bin(input logic [PTR_MAXW-1:0] g);
    logic [PTR_MAXW-1:0] b;
    b = g;
    for (int s = 1; s < PTR_MAXW; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_sched_rr_arbiter.sv
// ============================================================================
// rr_arbiter : round-robin one-hot arbiter; the requester after rr_last has
//              top priority, scanning upward modulo NREQ.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  input  logic [IW-1:0]   rr_last,
  output logic [NREQ-1:0] grant
);

  logic w_found;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    if (enable) begin
      for (int k = 1; k <= NREQ; k++) begin
        for (int j = 0; j < NREQ; j++) begin
          if (!w_found && req[j] && (((int'(rr_last) + k) % NREQ) == j)) begin
            grant[j] = 1'b1;
            w_found  = 1'b1;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_sched.sv
// ============================================================================
// fifo_wr_sched : write-domain controller of the async FIFO; arbitrates NREQ
//                 requesters onto the write port and owns wptr / wfull.
//                 Optional WR_ALMOST_FULL_EN adds registered walmost_full.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module fifo_wr_sched
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = 4,
  parameter int DATASIZE = 8,
  parameter int NREQ     = 4,
  parameter int AF_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATASIZE-1:0] req_data,
  output logic [NREQ-1:0]          grant,
  input  logic [ADDRSIZE:0]        wq2_rptr,
  output logic [ADDRSIZE:0]        wptr,
  output logic [ADDRSIZE-1:0]      waddr,
  output logic [DATASIZE-1:0]      wdata,
  output logic                     wen,
  output logic                     wfull
`ifdef WR_ALMOST_FULL_EN
  ,
  output logic                     walmost_full
`endif
);

  localparam int PW = ADDRSIZE + 1;
  localparam int IW = $clog2(NREQ);
  localparam logic [IW-1:0] RR_RESET = IW'(NREQ - 1);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wgray_d;
  logic          wfull_q, wfull_d;
  logic [IW-1:0] rr_last_q, rr_last_d;
  logic          w_arb_en;

  // Holding off grants during reset keeps a request from being consumed by a
  // write whose pointer is about to be cleared.
  assign w_arb_en = !wfull_q && !rst;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req     (req),
    .enable  (w_arb_en),
    .rr_last (rr_last_q),
    .grant   (grant)
  );

  always_comb begin
    wdata     = '0;
    rr_last_d = rr_last_q;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        wdata     = req_data[i*DATASIZE +: DATASIZE];
        rr_last_d = IW'(i);
      end
    end
  end

  assign wen     = |grant;
  assign waddr   = wbin_q[ADDRSIZE-1:0];
  assign wbin_d  = wbin_q + PW'(wen);
  assign wgray_d = PW'(bin2gray(PTR_MAXW'(wbin_d)));

  // Full when the write pointer has lapped the read pointer by exactly one
  // depth: in gray code that is the top two bits inverted, rest equal.
  assign wfull_d = (wgray_d == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q    <= '0;
      wptr_q    <= '0;
      wfull_q   <= 1'b0;
      rr_last_q <= RR_RESET;
    end else begin
      wbin_q    <= wbin_d;
      wptr_q    <= wgray_d;
      wfull_q   <= wfull_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign wptr  = wptr_q;
  assign wfull = wfull_q;

`ifdef WR_ALMOST_FULL_EN
  localparam int FIFO_DEPTH = 2**ADDRSIZE;

  logic [PW-1:0] w_rbin, w_used;
  logic          walmost_full_q, walmost_full_d;

  assign w_rbin         = PW'(gray2bin(PTR_MAXW'(wq2_rptr)));
  assign w_used         = wbin_d - w_rbin;
  assign walmost_full_d = (w_used >= PW'(FIFO_DEPTH - AF_LEVEL));

  always_ff @(posedge clk) begin
    if (rst) walmost_full_q <= 1'b0;
    else     walmost_full_q <= walmost_full_d;
  end

  assign walmost_full = walmost_full_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_sched.sv
// ============================================================================
// tb_fifo_wr_sched : directed scenarios plus randomized traffic for
//                    fifo_wr_sched, checked against an occupancy-level model.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_wr_sched;

  localparam int ADDRSIZE = 4;
  localparam int DATASIZE = 8;
  localparam int NREQ     = 4;
  localparam int AF_LEVEL = 2;
  localparam int DEPTH    = 16;
  localparam int PMOD     = 32;

  logic                     clk;
  logic                     rst;
  logic [NREQ-1:0]          req;
  logic [NREQ*DATASIZE-1:0] req_data;
  logic [NREQ-1:0]          grant;
  logic [ADDRSIZE:0]        wq2_rptr;
  logic [ADDRSIZE:0]        wptr;
  logic [ADDRSIZE-1:0]      waddr;
  logic [DATASIZE-1:0]      wdata;
  logic                     wen;
  logic                     wfull;
`ifdef WR_ALMOST_FULL_EN
  logic                     walmost_full;
`endif

  fifo_wr_sched #(
    .ADDRSIZE (ADDRSIZE),
    .DATASIZE (DATASIZE),
    .NREQ     (NREQ),
    .AF_LEVEL (AF_LEVEL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .grant        (grant),
    .wq2_rptr     (wq2_rptr),
    .wptr         (wptr),
    .waddr        (waddr),
    .wdata        (wdata),
    .wen          (wen),
    .wfull        (wfull)
`ifdef WR_ALMOST_FULL_EN
    ,
    .walmost_full (walmost_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit started = 1'b0;

  // Model state: number of writes so far (mod 32), last granted index, flags.
  int m_wcnt = 0;
  int m_rr   = NREQ - 1;
  bit m_full = 1'b0;
  bit m_af   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int gray_of(input int b);
    return (b ^ (b >> 1)) & (PMOD - 1);
  endfunction

  function automatic int bin_of(input int g);
    int b;
    b = 0;
    for (int s = 0; s <= ADDRSIZE; s++) b = b ^ (g >> s);
    return b & (PMOD - 1);
  endfunction

  function automatic int exp_gidx();
    if (m_full) return -1;
    for (int k = 1; k <= NREQ; k++) begin
      if (req[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    int wn;
    int used;
    if (rst) begin
      m_wcnt = 0;
      m_rr   = NREQ - 1;
      m_full = 1'b0;
      m_af   = 1'b0;
    end else begin
      g    = exp_gidx();
      wn   = (g >= 0) ? (m_wcnt + 1) % PMOD : m_wcnt;
      used = (wn - bin_of(int'(wq2_rptr)) + PMOD) % PMOD;
      m_full = (used == DEPTH);
      m_af   = (used >= DEPTH - AF_LEVEL);
      if (g >= 0) m_rr = g;
      m_wcnt = wn;
    end
  end

  always @(negedge clk) begin
    int g;
    if (started) begin
      g = exp_gidx();
      if (!rst) begin
        chk("grant", 32'(grant), (g >= 0) ? (32'd1 << g) : 32'd0);
        chk("wen",   32'(wen),   (g >= 0) ? 32'd1 : 32'd0);
        chk("wdata", 32'(wdata), (g >= 0) ? ((req_data >> (g * DATASIZE)) & 32'hFF) : 32'd0);
      end
      chk("waddr", 32'(waddr), 32'(m_wcnt % DEPTH));
      chk("wptr",  32'(wptr),  32'(gray_of(m_wcnt)));
      chk("wfull", 32'(wfull), 32'(m_full));
`ifdef WR_ALMOST_FULL_EN
      chk("walmost_full", 32'(walmost_full), 32'(m_af));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [3:0] rr_a [5];
  logic [3:0] rr_b [3];
  int rcnt;

  initial begin
    rst = 1'b1; req = 4'b1111; req_data = '0; wq2_rptr = '0;
    tick(); tick();
    started = 1'b1;

    // Fill from requester 0 with the read pointer parked at zero.
    rst = 1'b0; req = 4'b0001;
    for (int i = 0; i < 16; i++) begin
      req_data[7:0] = 8'(i);
      @(negedge clk);
      if (i == 0) begin
        chk("rst_wptr",  32'(wptr),  32'd0);
        chk("rst_wfull", 32'(wfull), 32'd0);
        chk("first_grant", 32'(grant), 32'b0001);
      end
      chk("fill_waddr", 32'(waddr), 32'(i));
      tick();
    end
    @(negedge clk);
    chk("full_set",   32'(wfull), 32'd1);
    chk("full_wptr",  32'(wptr),  32'b11000);
    chk("full_grant", 32'(grant), 32'd0);
    chk("full_wen",   32'(wen),   32'd0);
    tick();

    // Read side advances by one: exactly one more write, then full again.
    wq2_rptr = 5'b00001;
    @(negedge clk);
    chk("rel_still_full", 32'(wfull), 32'd1);
    tick();
    @(negedge clk);
    chk("rel_wfull_low", 32'(wfull), 32'd0);
    chk("rel_grant",     32'(grant), 32'b0001);
    tick();
    @(negedge clk);
    chk("rel_refull", 32'(wfull), 32'd1);
    chk("rel_wptr",   32'(wptr),  32'b11001);
    chk("rel_nogrant", 32'(grant), 32'd0);

    // Round robin with the read pointer keeping pace.
    tick();
    rst = 1'b1; req = '0; wq2_rptr = '0;
    tick();
    rst = 1'b0; req = 4'b1111;
    rr_a[0] = 4'b0001; rr_a[1] = 4'b0010; rr_a[2] = 4'b0100; rr_a[3] = 4'b1000; rr_a[4] = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      wq2_rptr = 5'(gray_of(m_wcnt));
      req_data = $urandom;
      @(negedge clk);
      chk("rr_all", 32'(grant), 32'(rr_a[k]));
      tick();
    end
    req = 4'b1010;
    rr_b[0] = 4'b0010; rr_b[1] = 4'b1000; rr_b[2] = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      wq2_rptr = 5'(gray_of(m_wcnt));
      @(negedge clk);
      chk("rr_sparse", 32'(grant), 32'(rr_b[k]));
      tick();
    end

    // Reset in the middle of traffic.
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0; req = 4'b1111;
    for (int k = 0; k < 7; k++) begin
      wq2_rptr = 5'(gray_of(m_wcnt));
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; req = '0;
    @(negedge clk);
    chk("midrst_wptr",  32'(wptr),  32'd0);
    chk("midrst_waddr", 32'(waddr), 32'd0);
    chk("midrst_wfull", 32'(wfull), 32'd0);
    tick();

    // Full pointer wrap with the read side tracking.
    req = 4'b0100;
    for (int i = 0; i < 32; i++) begin
      wq2_rptr = 5'(gray_of(m_wcnt));
      @(negedge clk);
      if (i == 15 || i == 16) chk("wrap_waddr", 32'(waddr), 32'(i % 16));
      tick();
    end
    @(negedge clk);
    chk("wrap_wptr", 32'(wptr), 32'd0);
    tick();

`ifdef WR_ALMOST_FULL_EN
    rst = 1'b1; req = '0; wq2_rptr = '0;
    tick();
    rst = 1'b0; req = 4'b0001;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 13) chk("af_13", 32'(walmost_full), 32'd0);
      tick();
    end
    req = '0;
    @(negedge clk);
    chk("af_14", 32'(walmost_full), 32'd1);
    tick();
`endif

    // Randomized traffic with a slow, randomly advancing reader.
    rst = 1'b1; req = '0; wq2_rptr = '0;
    tick();
    rst = 1'b0; rcnt = 0;
    for (int c = 0; c < 1500; c++) begin
      req      = 4'($urandom);
      req_data = $urandom;
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1; rcnt = 0;
      end else begin
        rst = 1'b0;
        if (rcnt != m_wcnt && $urandom_range(0, 3) == 0) rcnt = (rcnt + 1) % PMOD;
      end
      wq2_rptr = 5'(gray_of(rcnt));
      tick();
    end
    rst = 1'b0; req = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_wr_sched.md
Name: fifo_wr_sched

Overview:
- Write-side controller for the async FIFO, running in the write clock domain.
- Shares the single FIFO write port between NREQ requesters using round-robin arbitration.
- Owns the binary and gray write pointers and the full flag.
- Consumes the read pointer already synchronized into the write domain by the r2w synchronizer; drives the dual-port memory write port and the gray pointer handed to the read-side synchronizer.

Parameters:
- ADDRSIZE, 4, memory address width; FIFO depth = 2**ADDRSIZE.
- DATASIZE, 8, data word width.
- NREQ, 4, number of requesters (2..8).
- AF_LEVEL, 2, free-slot threshold for almost-full (used only with the optional feature).

Ports:
- clk  in  1  write-domain clock.
- rst  in  1  synchronous active-high reset.
- req  in  NREQ  per-requester write request; held with data until granted.
- req_data  in  NREQ*DATASIZE  packed data; slice i belongs to req[i].
- grant  out  NREQ  one-hot accept strobe, combinational, same cycle as the write.
- wq2_rptr  in  ADDRSIZE+1  synchronized gray read pointer (output of r2w).
- wptr  out  ADDRSIZE+1  registered gray write pointer, to the read-side synchronizer.
- waddr  out  ADDRSIZE  memory write address = wbin[ADDRSIZE-1:0].
- wdata  out  DATASIZE  memory write data, muxed from the granted slice.
- wen  out  1  memory write enable = |grant.
- wfull  out  1  registered full flag.

Behaviour:
- Reset (rst=1 at posedge clk): wbin=0, wptr=0, wfull=0, rr_last=NREQ-1 (requester 0 has priority first). grant, wen, wdata follow combinationally from the reset state: grant=0 while req=0, wdata=0 when no grant.
- Arbitration: if !wfull and |req, grant the first asserted req scanning upward from rr_last+1 modulo NREQ. Exactly one grant bit is set. If wfull, grant=0 regardless of req.
- On a grant: wen=1, waddr=wbin[ADDRSIZE-1:0], wdata=req_data slice of the granted index, all in the same cycle.
- At posedge with a grant: wbin <= wbin+1 (wraps mod 2**(ADDRSIZE+1)); rr_last <= granted index.
- Without a grant, wbin and rr_last hold.
- Gray pointer: wgray_next = (wbin_next>>1)^wbin_next; wptr <= wgray_next every cycle.
- Full: wfull <= (wgray_next == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
  - Full asserts at the edge that completes the 2**ADDRSIZE-th outstanding write.
  - Full deasserts at the first edge after wq2_rptr advances.
  - Full is pessimistic by the synchronizer latency; no write is ever accepted while full.
- Simultaneous request and full: request is not granted and must be held; no data loss.
- wq2_rptr is sampled only through the full comparison; no other state depends on it.
- Reset mid-operation clears pointers and the flag at that edge. Any pending request is re-arbitrated from requester 0.

Optional Feature:
- Macro WR_ALMOST_FULL_EN.
- With it: extra output walmost_full (1 bit, registered, reset 0).
  - Convert wq2_rptr gray→binary (rbin).
  - walmost_full <= ((wbin_next - rbin) mod 2**(ADDRSIZE+1)) >= 2**ADDRSIZE - AF_LEVEL.
  - walmost_full is advisory only; it does not gate grants.
- Without it: the port, converter and comparator are absent; AF_LEVEL is unused.

Decomposition:
- Package fifo_pkg:
  - bin2gray and gray2bin functions parameterized on width.
  - Localparam DEPTH = 2**ADDRSIZE.
  - Shared by r2w, the read-side controller and this block.
- One sub-module, rr_arbiter (NREQ): inputs req, enable, rr_last; output one-hot grant.
- Pointer, full and mux logic stay in fifo_wr_sched.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111 → wptr=0, wfull=0; after release the first grant=4'b0001, waddr=0.
- Fill: req=4'b0001 held, req_data slice0 = count, wq2_rptr=0 → 16 grants with waddr 0..15; wfull=1 after the 16th edge; wptr=5'b11000; the 17th cycle gives grant=0, wen=0.
- Round robin: wq2_rptr keeps pace, req=4'b1111 held → grants 0001,0010,0100,1000,0001. Then with req=4'b1010 and rr_last=0 → grants 0010,1000,0010.
- Full release: from full, set wq2_rptr=5'b00001 (gray 1) → wfull falls at the next edge; exactly one more grant; wfull re-asserts with wptr=5'b11001.
- Wrap: 32 writes with wq2_rptr tracking → waddr wraps 15→0; wptr returns to 5'b00000; wfull never asserts.
- Mid-op reset: rst=1 for 1 cycle after 7 writes → wptr=0, waddr=0, wfull=0 next cycle. With WR_ALMOST_FULL_EN and AF_LEVEL=2: walmost_full=1 after 14 writes with wq2_rptr=0.
